// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: fetch and debug read requesters plus the ROM read port.
// The arbiter takes the slave side; the requesters/ROM model take the master side.
interface imem_arbiter_if #(
  parameter int ALEN = 32,
  parameter int XLEN = 32
);
  logic            if_req_valid;
  logic [ALEN-1:0] if_req_addr;
  logic            if_req_ready;
  logic            if_rsp_valid;
  logic [XLEN-1:0] if_rsp_data;
  logic            if_rsp_err;

  logic            dbg_req_valid;
  logic [ALEN-1:0] dbg_req_addr;
  logic            dbg_req_ready;
  logic            dbg_rsp_valid;
  logic [XLEN-1:0] dbg_rsp_data;
  logic            dbg_rsp_err;

  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr, dbg_req_valid, dbg_req_addr, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_err, mem_addr
  );

  modport master (
    output if_req_valid, if_req_addr, dbg_req_valid, dbg_req_addr, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_err, mem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester (fetch, debug) arbiter for an async-read instruction ROM.
// Fetch has priority; debug is force-granted after MAX_WAIT stalled cycles.
module imem_arbiter_rsp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc,
  input  logic            mis,
  input  logic [XLEN-1:0] rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // Data/err only move on acceptance so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= acc;
      if (acc) begin
        rsp_data <= mis ? NOP : rdata;
        rsp_err  <= mis;
      end
    end
  end
endmodule

module imem_arbiter #(
  parameter int ALEN     = 32,
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);
  localparam int NREQ = 2;  // lane 0 = fetch, lane 1 = debug

  logic [3:0]                 wait_cnt;
  logic                       force_dbg;
  logic [NREQ-1:0]            grant;
  logic [ALEN-1:0]            mem_addr;
  logic                       mis;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0][XLEN-1:0]  rsp_data;
  logic [NREQ-1:0]            rsp_err;

  assign force_dbg = bus.dbg_req_valid && (wait_cnt >= 4'(MAX_WAIT));
  assign grant[1]  = !rst && bus.dbg_req_valid && (force_dbg || !bus.if_req_valid);
  assign grant[0]  = !rst && bus.if_req_valid && !force_dbg;

  // Idle cycles still present the fetch address to the ROM.
  assign mem_addr     = grant[1] ? bus.dbg_req_addr : bus.if_req_addr;
  assign mis          = |mem_addr[1:0];
  assign bus.mem_addr = mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (!bus.dbg_req_valid || grant[1])
      wait_cnt <= '0;
    else if (wait_cnt != 4'hF)
      wait_cnt <= wait_cnt + 4'd1;
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    imem_arbiter_rsp #(.XLEN(XLEN)) u_rsp (
      .clk       (clk),
      .rst       (rst),
      .acc       (grant[i]),
      .mis       (mis),
      .rdata     (bus.mem_rdata),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i]),
      .rsp_err   (rsp_err[i])
    );
  end

  assign bus.if_req_ready  = grant[0];
  assign bus.if_rsp_valid  = rsp_valid[0];
  assign bus.if_rsp_data   = rsp_data[0];
  assign bus.if_rsp_err    = rsp_err[0];
  assign bus.dbg_req_ready = grant[1];
  assign bus.dbg_rsp_valid = rsp_valid[1];
  assign bus.dbg_rsp_data  = rsp_data[1];
  assign bus.dbg_rsp_err   = rsp_err[1];
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them against the DUT.
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ALEN(32), .XLEN(32)) bus ();

  imem_arbiter #(.ALEN(32), .XLEN(32), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ROM model; misaligned addresses return junk the DUT must replace.
  always_comb begin
    case (bus.mem_addr)
      32'h0000_0000: bus.mem_rdata = 32'h0000_00A0;
      32'h0000_0004: bus.mem_rdata = 32'h0000_00A4;
      32'h0000_0008: bus.mem_rdata = 32'h0000_00A8;
      32'h0000_0010: bus.mem_rdata = 32'hDEAD_BEEF;
      32'h0000_0020: bus.mem_rdata = 32'h1111_2222;
      32'h0000_0040: bus.mem_rdata = 32'hCAFE_0040;
      default:       bus.mem_rdata = 32'hBAD0_0000 | bus.mem_addr;
    endcase
  end

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q[2][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  string       nm[2] = '{"if", "dbg"};
  logic        mv[2];
  logic [31:0] md[2];
  logic        me[2];
  logic        due_now;
  logic [31:0] last_d[2] = '{32'h0, 32'h0};
  logic        last_e[2] = '{1'b0, 1'b0};

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: exclusivity, exact one-cycle latency, data/err, hold between responses.
  always @(negedge clk) begin
    mv[0] = bus.if_rsp_valid;  md[0] = bus.if_rsp_data;  me[0] = bus.if_rsp_err;
    mv[1] = bus.dbg_rsp_valid; md[1] = bus.dbg_rsp_data; me[1] = bus.dbg_rsp_err;
    chk("ready_exclusive", {31'b0, bus.if_req_ready & bus.dbg_req_ready}, 32'd0);
    for (int r = 0; r < 2; r++) begin
      if (rst) begin
        last_d[r] = 32'h0;
        last_e[r] = 1'b0;
      end
      due_now = (q[r].size() != 0) && (q[r][0].due == cyc);
      chk({nm[r], "_rsp_valid"}, {31'b0, mv[r]}, {31'b0, due_now});
      if (due_now) begin
        if (mv[r]) begin
          chk({nm[r], "_rsp_data"}, md[r], q[r][0].d);
          chk({nm[r], "_rsp_err"}, {31'b0, me[r]}, {31'b0, q[r][0].e});
        end
        last_d[r] = q[r][0].d;
        last_e[r] = q[r][0].e;
        void'(q[r].pop_front());
      end else if (!mv[r]) begin
        chk({nm[r], "_hold_data"}, md[r], last_d[r]);
        chk({nm[r], "_hold_err"}, {31'b0, me[r]}, {31'b0, last_e[r]});
      end
    end
  end

  // Drive one cycle of requests (called #1 after a rising edge), check grants
  // and the ROM address, then queue the expected response for the granted side.
  task automatic step(input logic ifv, input logic [31:0] ifa,
                      input logic dv, input logic [31:0] da,
                      input logic xi, input logic xd,
                      input logic [31:0] xdat, input logic xerr, input logic push);
    exp_t x;
    bus.if_req_valid  = ifv;
    bus.if_req_addr   = ifa;
    bus.dbg_req_valid = dv;
    bus.dbg_req_addr  = da;
    @(negedge clk);
    chk("if_req_ready", {31'b0, bus.if_req_ready}, {31'b0, xi});
    chk("dbg_req_ready", {31'b0, bus.dbg_req_ready}, {31'b0, xd});
    chk("mem_addr", bus.mem_addr, xd ? da : ifa);
    x.due = cyc + 1;
    x.d   = xdat;
    x.e   = xerr;
    if (push && xi) q[0].push_back(x);
    if (push && xd) q[1].push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_rsp_valid", {31'b0, bus.if_rsp_valid}, 32'd0);
    chk("rst_if_rsp_data", bus.if_rsp_data, 32'd0);
    chk("rst_if_rsp_err", {31'b0, bus.if_rsp_err}, 32'd0);
    chk("rst_dbg_rsp_valid", {31'b0, bus.dbg_rsp_valid}, 32'd0);
    chk("rst_dbg_rsp_data", bus.dbg_rsp_data, 32'd0);
    chk("rst_dbg_rsp_err", {31'b0, bus.dbg_rsp_err}, 32'd0);
    chk("rst_if_req_ready", {31'b0, bus.if_req_ready}, 32'd0);
    chk("rst_dbg_req_ready", {31'b0, bus.dbg_req_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h0;
    bus.dbg_req_valid = 1'b1;
    bus.dbg_req_addr  = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch stream straight out of reset, no bubbles
    step(1, 32'h0, 0, 32'h0, 1, 0, 32'h0000_00A0, 0, 1);
    step(1, 32'h4, 0, 32'h0, 1, 0, 32'h0000_00A4, 0, 1);
    step(1, 32'h8, 0, 32'h0, 1, 0, 32'h0000_00A8, 0, 1);
    // Debug-only, then misaligned fetch, then idle
    step(0, 32'h4, 1, 32'h10, 0, 1, 32'hDEAD_BEEF, 0, 1);
    step(1, 32'h6, 0, 32'h0, 1, 0, 32'h0000_0013, 1, 1);
    step(0, 32'h24, 0, 32'h40, 0, 0, 32'h0, 0, 1);

    // Continuous contention: 4 fetch grants then 1 forced debug grant
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) step(1, 32'h20, 1, 32'h40, 0, 1, 32'hCAFE_0040, 0, 1);
      else            step(1, 32'h20, 1, 32'h40, 1, 0, 32'h1111_2222, 0, 1);
    end
    step(0, 32'h0, 1, 32'h42, 0, 1, 32'h0000_0013, 1, 1);

    // Debug dropping its request clears the wait counter
    repeat (3) step(1, 32'h20, 1, 32'h40, 1, 0, 32'h1111_2222, 0, 1);
    step(1, 32'h20, 0, 32'h40, 1, 0, 32'h1111_2222, 0, 1);
    repeat (4) step(1, 32'h20, 1, 32'h40, 1, 0, 32'h1111_2222, 0, 1);
    step(1, 32'h20, 1, 32'h40, 0, 1, 32'hCAFE_0040, 0, 1);

    // Reset right after an acceptance discards that response
    step(1, 32'h8, 0, 32'h0, 1, 0, 32'h0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 32'h8, 0, 32'h0, 1, 0, 32'h0000_00A8, 0, 1);
    step(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 1);

    chk("if_queue_drained", q[0].size(), 32'd0);
    chk("dbg_queue_drained", q[1].size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
